// File: rtl/load_store_unit_if.sv
// Processor request/response and word-memory signals of the load/store unit.
// The unit takes the slave modport; the processor/memory side takes the master modport.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [17:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        W;
  logic [15:0] realaddr;
  logic [31:0] dout;
  logic [31:0] din;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready, din,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, W, realaddr, dout
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready, din,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, W, realaddr, dout
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit over a 32-bit word memory; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of force-aligning them.
module load_store_unit (
  input  logic              clk,
  input  logic              resetn,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSV  = 2'b11;

  state_t      state_q, state_d;
  logic        live_q, live_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] realaddr_q, realaddr_d;
  logic [31:0] dout_q, dout_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic        req_ready_s;
  logic        accept_s;
  logic        bad_s;
  logic [1:0]  lane_s;

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = word[7:0];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{~uns & b[7]}}, b};
      SZ_HALF: r = {{16{~uns & h[15]}}, h};
      SZ_WORD: r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] wdata,
                                        input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'b00:   r[7:0]   = wdata[7:0];
          2'b01:   r[15:8]  = wdata[7:0];
          2'b10:   r[23:16] = wdata[7:0];
          2'b11:   r[31:24] = wdata[7:0];
          default: r[7:0]   = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) r[31:16] = wdata[15:0];
        else         r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  assign req_ready_s   = live_q & (state_q == IDLE);
  assign accept_s      = bus.req_valid & req_ready_s;
  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.W         = (state_q == WR);
  assign bus.realaddr  = realaddr_q;
  assign bus.dout      = dout_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_fault = fault_q;

  // Effective lane and fault decision for the request currently on the bus
  always_comb begin
    lane_s = bus.req_addr[1:0];
    bad_s  = (bus.req_size == SZ_RSV);
`ifdef LSU_MISALIGN_TRAP_EN
    case (bus.req_size)
      SZ_HALF: bad_s = bus.req_addr[0];
      SZ_WORD: bad_s = (bus.req_addr[1:0] != 2'b00);
      SZ_RSV:  bad_s = 1'b1;
      default: bad_s = 1'b0;
    endcase
`else
    case (bus.req_size)
      SZ_HALF: lane_s = {bus.req_addr[1], 1'b0};
      SZ_WORD: lane_s = 2'b00;
      default: lane_s = bus.req_addr[1:0];
    endcase
`endif
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    live_d     = 1'b1;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    lane_d     = lane_q;
    wdata_d    = wdata_q;
    realaddr_d = realaddr_q;
    dout_d     = dout_q;
    rdata_d    = rdata_q;
    fault_d    = fault_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          we_d       = bus.req_we;
          size_d     = bus.req_size;
          uns_d      = bus.req_unsigned;
          lane_d     = lane_s;
          wdata_d    = bus.req_wdata;
          realaddr_d = bus.req_addr[17:2];
          rdata_d    = 32'h0000_0000;
          fault_d    = 1'b0;
          if (bad_s) begin
            fault_d = 1'b1;
            state_d = RESP;
          end else if (bus.req_we && (bus.req_size == SZ_WORD)) begin
            dout_d  = bus.req_wdata;
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        // Sub-word stores merge into the fetched word; loads extract and extend it
        if (we_q) begin
          dout_d  = merge(bus.din, wdata_q, size_q, lane_q);
          state_d = WR;
        end else begin
          rdata_d = extract(bus.din, size_q, lane_q, uns_q);
          state_d = RESP;
        end
      end
      WR: begin
        rdata_d = 32'h0000_0000;
        fault_d = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
        else               state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      live_q     <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      lane_q     <= 2'b00;
      wdata_q    <= 32'h0000_0000;
      realaddr_q <= 16'h0000;
      dout_q     <= 32'h0000_0000;
      rdata_q    <= 32'h0000_0000;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      live_q     <= live_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      lane_q     <= lane_d;
      wdata_q    <= wdata_d;
      realaddr_q <= realaddr_d;
      dout_q     <= dout_d;
      rdata_q    <= rdata_d;
      fault_q    <= fault_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word-memory model, vector table with response scoreboard,
// plus hand-written backpressure and reset-during-write sequences.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
  } rsp_t;

  logic clk;
  logic resetn;
  int   errors;
  int   checks;
  int   w_total;
  logic [31:0] mem [0:65535];
  rsp_t exp_q [$];
  vec_t tbl [25];

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.din = mem[bus.realaddr];

  always @(posedge clk) begin
    if (bus.W) begin
      mem[bus.realaddr] <= bus.dout;
      w_total <= w_total + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input vec_t v);
    if (v.exp_fault) return 1;
    if (!v.we) return 2;
    if (v.size == 2'b10) return 2;
    return 3;
  endfunction

  function automatic int exp_w(input vec_t v);
    if (v.exp_fault) return 0;
    return v.we ? 1 : 0;
  endfunction

  task automatic do_req(input vec_t v);
    int   lat;
    int   w0;
    rsp_t e;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = v.we;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    chk({v.name, " ready"}, {31'd0, bus.req_ready}, 32'd1);
    w0 = w_total;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    exp_q.push_back('{v.exp_rdata, v.exp_fault});
    chk({v.name, " realaddr"}, {16'd0, bus.realaddr}, {16'd0, v.addr[17:2]});
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({v.name, " latency"}, lat, exp_lat(v));
    if (bus.rsp_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({v.name, " rdata"}, bus.rsp_rdata, e.rdata);
      chk({v.name, " fault"}, {31'd0, bus.rsp_fault}, {31'd0, e.fault});
    end else begin
      chk({v.name, " rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
      exp_q.delete();
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk({v.name, " W cycles"}, w_total - w0, exp_w(v));
    chk({v.name, " idle after"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    rsp_t        e;
    logic [31:0] held;
    logic [31:0] old_word;
    int          w0;
    errors  = 0;
    checks  = 0;
    w_total = 0;

    tbl[0]  = '{"ws_deadbeef", 1'b1, 2'b10, 1'b0, 18'h00010, 32'hDEADBEEF, 32'h0, 1'b0};
    tbl[1]  = '{"wl_deadbeef", 1'b0, 2'b10, 1'b0, 18'h00010, 32'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{"ws_11223344", 1'b1, 2'b10, 1'b0, 18'h00010, 32'h11223344, 32'h0, 1'b0};
    tbl[3]  = '{"bs_aa", 1'b1, 2'b00, 1'b0, 18'h00012, 32'h000000AA, 32'h0, 1'b0};
    tbl[4]  = '{"bl_s_aa", 1'b0, 2'b00, 1'b0, 18'h00012, 32'h0, 32'hFFFFFFAA, 1'b0};
    tbl[5]  = '{"bl_u_aa", 1'b0, 2'b00, 1'b1, 18'h00012, 32'h0, 32'h000000AA, 1'b0};
    tbl[6]  = '{"ws_80017fff", 1'b1, 2'b10, 1'b0, 18'h00014, 32'h80017FFF, 32'h0, 1'b0};
    tbl[7]  = '{"hl_s_hi", 1'b0, 2'b01, 1'b0, 18'h00016, 32'h0, 32'hFFFF8001, 1'b0};
    tbl[8]  = '{"hl_u_hi", 1'b0, 2'b01, 1'b1, 18'h00016, 32'h0, 32'h00008001, 1'b0};
    tbl[9]  = '{"hl_s_lo", 1'b0, 2'b01, 1'b0, 18'h00014, 32'h0, 32'h00007FFF, 1'b0};
    tbl[10] = '{"bl_s_l0", 1'b0, 2'b00, 1'b0, 18'h00014, 32'h0, 32'hFFFFFFFF, 1'b0};
    tbl[11] = '{"hs_1234", 1'b1, 2'b01, 1'b0, 18'h00016, 32'hFFFF1234, 32'h0, 1'b0};
    tbl[12] = '{"wl_after_hs", 1'b0, 2'b10, 1'b0, 18'h00014, 32'h0, 32'h12347FFF, 1'b0};
    tbl[13] = '{"rsv_load", 1'b0, 2'b11, 1'b0, 18'h00014, 32'h0, 32'h0, 1'b1};
    tbl[14] = '{"rsv_store", 1'b1, 2'b11, 1'b0, 18'h00014, 32'h55555555, 32'h0, 1'b1};
    tbl[15] = '{"ws_cafef00d", 1'b1, 2'b10, 1'b0, 18'h00000, 32'hCAFEF00D, 32'h0, 1'b0};
    tbl[16] = '{"wl_mis_02", 1'b0, 2'b10, 1'b0, 18'h00002, 32'h0, TRAP ? 32'h0 : 32'hCAFEF00D, TRAP};
    tbl[17] = '{"hl_mis_17", 1'b0, 2'b01, 1'b0, 18'h00017, 32'h0, TRAP ? 32'h0 : 32'h00001234, TRAP};
    tbl[18] = '{"ws_top", 1'b1, 2'b10, 1'b0, 18'h3FFFC, 32'hA1B2C3D4, 32'h0, 1'b0};
    tbl[19] = '{"bs_top_l3", 1'b1, 2'b00, 1'b0, 18'h3FFFF, 32'h1234565E, 32'h0, 1'b0};
    tbl[20] = '{"bl_u_top_l3", 1'b0, 2'b00, 1'b1, 18'h3FFFF, 32'h0, 32'h0000005E, 1'b0};
    tbl[21] = '{"wl_top", 1'b0, 2'b10, 1'b0, 18'h3FFFC, 32'h0, 32'h5EB2C3D4, 1'b0};
    tbl[22] = '{"wl_no_wrap", 1'b0, 2'b10, 1'b0, 18'h00000, 32'h0, 32'hCAFEF00D, 1'b0};
    tbl[23] = '{"ws_mis_03", 1'b1, 2'b10, 1'b0, 18'h00003, 32'h0BADF00D, 32'h0, TRAP};
    tbl[24] = '{"wl_after_mis", 1'b0, 2'b10, 1'b0, 18'h00000, 32'h0, TRAP ? 32'hCAFEF00D : 32'h0BADF00D, 1'b0};

    resetn           = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 18'h0;
    bus.req_wdata    = 32'h0;
    bus.rsp_ready    = 1'b0;

    // Reset values, and req_ready rising only after the first edge out of reset
    #12;
    chk("rst req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst W", {31'd0, bus.W}, 32'd0);
    chk("rst realaddr", {16'd0, bus.realaddr}, 32'd0);
    chk("rst dout", bus.dout, 32'd0);
    chk("rst rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst rsp_fault", {31'd0, bus.rsp_fault}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("ready before edge", {31'd0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("ready after edge", {31'd0, bus.req_ready}, 32'd1);

    for (int i = 0; i < 25; i++) do_req(tbl[i]);
    chk("mem word4", mem[4], 32'h11AA3344);
    chk("mem word5", mem[5], 32'h12347FFF);
    chk("mem wordFFFF", mem[16'hFFFF], 32'h5EB2C3D4);

    // Response backpressure: hold rsp_ready low for 5 cycles
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 18'h00010;
    chk("bp ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    exp_q.push_back('{32'h11AA3344, 1'b0});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    held = bus.rsp_rdata;
    chk("bp rdata", held, e.rdata);
    for (int c = 0; c < 5; c++) begin
      chk("bp hold valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp hold rdata", bus.rsp_rdata, e.rdata);
      chk("bp hold req_ready", {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    bus.rsp_ready = 1'b1;
    chk("bp valid before release", {31'd0, bus.rsp_valid}, 32'd1);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk("bp idle req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("bp idle rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);

    // Reset pulsed during the write cycle of a byte store
    old_word = mem[4];
    w0 = w_total;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_size     = 2'b00;
    bus.req_addr     = 18'h00011;
    bus.req_wdata    = 32'h00000077;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rw W in WR", {31'd0, bus.W}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rw W async drop", {31'd0, bus.W}, 32'd0);
    chk("rw realaddr", {16'd0, bus.realaddr}, 32'd0);
    chk("rw dout", bus.dout, 32'd0);
    chk("rw req_ready", {31'd0, bus.req_ready}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rw ready before edge", {31'd0, bus.req_ready}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("rw no rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    end
    chk("rw ready after", {31'd0, bus.req_ready}, 32'd1);
    chk("rw word unchanged", mem[4], old_word);
    chk("rw no W edge", w_total - w0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 resetn  input  1  asynchronous, active-low reset.
REQ-003 req_valid  input  1  processor memory request present.
REQ-004 req_ready  output  1  unit can accept a request.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-007 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-008 req_addr  input  18  byte address, little-endian; [17:2] = word address, [1:0] = lane.
REQ-009 req_wdata  input  32  store data, right-justified.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  processor accepts response.
REQ-012 rsp_rdata  output  32  extended load data; 0 for stores and faults.
REQ-013 rsp_fault  output  1  request rejected with no memory access.
REQ-014 W  output  1  word-memory write strobe.
REQ-015 realaddr  output  16  word-memory address.
REQ-016 dout  output  32  word-memory write data.
REQ-017 din  input  32  word-memory read data, combinational from realaddr.

Function
REQ-018 FSM states IDLE, RD, WR, RESP; state, realaddr, dout and the captured word are registers; W SHALL equal (state==WR), decoded from the state register only.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1 on a rising edge, and all request fields are latched on acceptance.
REQ-020 On acceptance, realaddr SHALL be loaded with req_addr[17:2].
REQ-021 Load: IDLE->RD->RESP; in RD, W=0 and din is captured at the edge; lane/size extraction and extension then set rsp_rdata.
REQ-022 Word store: IDLE->WR->RESP; dout = req_wdata; W=1 for exactly one cycle.
REQ-023 Byte/half store: IDLE->RD->WR->RESP (read-modify-write); only the addressed lane(s) of the captured word are replaced by req_wdata[7:0] or [15:0].
REQ-024 Byte lane n covers bits [8n+7:8n]; half at lane 0 covers [15:0] and at lane 2 covers [31:16].
REQ-025 In RESP, rsp_valid SHALL be 1 and held with stable rsp_rdata/rsp_fault until rsp_ready=1, then the FSM moves to IDLE on that edge.
REQ-026 req_size=11 SHALL fault: IDLE->RESP, rsp_fault=1, no RD/WR, W never asserted.
REQ-027 Minimum occupancy is 3 cycles per load or word store and 4 per sub-word store; no request overlap.
REQ-028 realaddr 0xFFFF and lane 3 SHALL be handled with no wrap into the next word.

Reset
REQ-029 While resetn=0: state=IDLE, W=0, realaddr=0, dout=0, rsp_valid=0, rsp_rdata=0, rsp_fault=0, req_ready=0; req_ready rises after the first clock edge with resetn=1.
REQ-030 Reset asserted in WR SHALL drop W immediately and asynchronously; the pending store is abandoned; no response is issued.

Configuration
REQ-031 Macro LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL fault as in REQ-026.
REQ-032 Macro LSU_MISALIGN_TRAP_EN undefined: misaligned addresses are force-aligned (half clears bit 0, word clears bits [1:0]), and the request proceeds with no fault.

Verification
REQ-033 Word store 0xDEADBEEF @0x00010, then word load @0x00010 -> realaddr=0x0004, W high one cycle, rsp_rdata=0xDEADBEEF.
REQ-034 Memory word 0x11223344 @0x0004; byte store 0xAA @0x00012 -> memory word becomes 0x11AA3344; signed byte load @0x00012 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
REQ-035 Half load @0x00016 from word 0x8001_7FFF -> signed 0xFFFF8001, unsigned 0x00008001.
REQ-036 rsp_ready held 0 for 5 cycles -> rsp_valid stays 1, rsp_rdata stable, req_ready stays 0; the FSM returns to IDLE on the edge where rsp_ready=1.
REQ-037 req_size=11, then a word load @0x00002 with the macro defined -> both give rsp_fault=1 with W=0; with the macro undefined, the load returns the word @0x00000.
REQ-038 resetn pulsed low during WR of a byte store -> W falls without a clock edge, the target word is unchanged, and rsp_valid is never asserted.
